// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Operand issuer / result consumer side.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_adder.sv
// Carry-segmented pipelined adder/subtractor. Stage k adds segment k
// (bits [k*CW +: CW]) using the carry registered by stage k-1; operands for
// the segments still to come ride along, finished result segments move forward.
// Each stage is a valid/ready slot, so bubbles collapse when the output stalls.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,   // async, active low
  pipelined_adder_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  // stage registers
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];   // already inverted in sub mode
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic [STAGES-1:0] r_vld;
  logic             r_cout, r_ovf, r_zero;

  // stage inputs / combinational results
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic [WIDTH-1:0]  w_s_nxt [STAGES];
  logic [CW:0]       w_sum   [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_c_out;
  logic [STAGES:0]   w_rdy;
  logic              w_ovf;

  assign w_rdy[STAGES] = bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtract is A + ~B + ~borrow; the inversion happens once, at entry.
      assign w_a_in[k] = bus.a;
      assign w_b_in[k] = bus.sub ? ~bus.b : bus.b;
      assign w_c_in[k] = bus.sub ? ~bus.cin : bus.cin;
      assign w_s_in[k] = '0;
      assign w_v_in[k] = bus.in_valid;
    end else begin : g_next
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_s_in[k] = r_s[k-1];
      assign w_v_in[k] = r_vld[k-1];
    end

    // A slot can take a new op if it is empty or its occupant moves on.
    assign w_rdy[k] = !r_vld[k] || w_rdy[k+1];

    assign w_sum[k] = {1'b0, w_a_in[k][k*CW +: CW]}
                    + {1'b0, w_b_in[k][k*CW +: CW]}
                    + {{CW{1'b0}}, w_c_in[k]};
    assign w_c_out[k] = w_sum[k][CW];
    // Segments at and above k are still zero in the travelling result,
    // so OR-ing the new segment in is enough.
    assign w_s_nxt[k] = w_s_in[k] | (WIDTH'(w_sum[k][CW-1:0]) << (k * CW));
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign w_ovf = w_c_out[STAGES-1]
               ^ (w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1]
                  ^ w_s_nxt[STAGES-1][WIDTH-1]);

  // Advance each slot when downstream has room; hold data otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) r_vld[k] <= w_v_in[k];
        if (w_rdy[k] && w_v_in[k]) begin
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= w_s_nxt[k];
          r_c[k] <= w_c_out[k];
        end
      end
      if (w_rdy[STAGES-1] && w_v_in[STAGES-1]) begin
        r_cout <= w_c_out[STAGES-1];
        r_ovf  <= w_ovf;
        r_zero <= (w_s_nxt[STAGES-1] == '0);
      end
    end
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.s         = r_s[STAGES-1];
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=32, STAGES=4): directed vectors with
// literal expectations plus an arithmetic reference model and scoreboard.
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   issued = 0;
  int   retired = 0;

  logic [W+2:0] exp_q[$];   // {s, cout, ovf, zero}

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    longint ua, ub, sa, sb, ures, sres;
    logic [W-1:0] s;
    logic co, ov;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    if (sub) begin
      ures = ua - ub - longint'(cin);
      sres = sa - sb - longint'(cin);
      co   = (ua >= ub + longint'(cin));
    end else begin
      ures = ua + ub + longint'(cin);
      sres = sa + sb + longint'(cin);
      co   = (ures >= 64'sh1_0000_0000);
    end
    s  = ures[W-1:0];
    ov = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
    return {s, co, ov, (s == '0)};
  endfunction

  // Scoreboard: retire on output transfer, record on input transfer.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {bus.s, bus.cout, bus.ovf, bus.zero}, 35'h0);
          bad++;  // an output with nothing outstanding is always wrong
        end else begin
          chk("scoreboard", {bus.s, bus.cout, bus.ovf, bus.zero}, exp_q.pop_front());
        end
        retired++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        issued++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One op, then check the 4-cycle latency and the result fields.
  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W+2:0] exp);
    set_op(a, b, cin, sub);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk({nm, "_early"}, bus.out_valid, 1'b0);
    tick();
    chk({nm, "_valid"}, bus.out_valid, 1'b1);
    chk(nm, {bus.s, bus.cout, bus.ovf, bus.zero}, exp);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, base, cyc;
    logic [W-1:0] hold;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_op('0, '0, 1'b0, 1'b0);

    // reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_flags", {bus.s, bus.cout, bus.ovf, bus.zero}, 35'h0);
    #10 reset = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // directed vectors: {s, cout, ovf, zero}
    directed("add_wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h0, 1'b1, 1'b0, 1'b1});
    directed("add_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
    directed("sub_borrow", 32'h5, 32'h7, 1'b0, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    directed("sub_cin",   32'h8000_0000, 32'h0, 1'b1, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    directed("add_cin",   32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, {32'h0001_0000, 1'b0, 1'b0, 1'b0});

    // back-to-back 100 ops, one result per cycle
    tick();
    base = retired;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      set_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", acc, 100);
    tick(); tick();
    @(negedge clk); #1;
    chk("b2b_count_m1", retired - base, 99);
    tick();
    @(negedge clk); #1;
    chk("b2b_count", retired - base, 100);

    // fill under backpressure
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_op(32'h100 * (i + 1), 32'h3 + i, 1'b0, 1'(i % 2));
      if (bus.in_ready) acc++;
      tick();
    end
    chk("fill_accepts", acc, ST);
    chk("fill_in_ready", bus.in_ready, 1'b0);
    hold = bus.s;
    tick(); tick(); tick();
    chk("stall_s_stable", bus.s, hold);
    chk("stall_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    base = retired;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("drain_count", retired - base, ST);
    chk("drain_empty", exp_q.size(), 0);

    // random valid/ready traffic
    base = issued;
    cyc = 0;
    while ((issued - base) < 10000 && cyc < 60000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      set_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      cyc++;
    end
    chk("rand_issued", issued - base, 10000);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_balance", retired, issued);

    // reset with 3 ops in flight
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(32'h1111_1111 * (i + 1), 32'h1, 1'b0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_s", bus.s, 32'h0);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    directed("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1,
             {32'h0123_4567, 1'b1, 1'b0, 1'b0});
    tick(); tick();
    chk("post_rst_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
